// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, constants and word helpers.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [0:31]  aes_word_t;
    typedef logic [0:127] aes_block_t;

    typedef enum logic {
        KX_IDLE,
        KX_EMIT
    } kx_state_t;

    // Round constants, indexed by round number
    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Left rotate by one byte
    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[8:31], w[0:7]};
    endfunction

    // Rcon in the top byte; rounds outside 1..10 give zero
    function automatic aes_word_t rcon_word(input logic [3:0] r);
        int idx;
        idx = int'(r);
        if (idx >= 1 && idx <= 10)
            return {RCON[idx], 24'h0};
        return '0;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES byte S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] sbout
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // a^254 is the inverse (and maps 0 to 0), then the fixed affine transform
    always_comb begin
        sq  = {x, y};
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        sbout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: one S-box lane per byte, high nibble on x, low nibble on y.
module aes_sub_word
    import aes_pkg::*;
#(
    parameter int NUM_LANES = 4
) (
    input  aes_word_t din,
    output aes_word_t dout
);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        aes_sbox u_sbox (
            .x     (din[8*g +: 4]),
            .y     (din[8*g+4 +: 4]),
            .sbout (dout[8*g +: 8])
        );
    end

endmodule

// File: rtl/aes_key_expand_iter.sv
// Iterative AES-128 key schedule: one round key per handshake, forward or reverse.
module aes_key_expand_iter
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [0:127] key_in,
    input  logic         decrypt,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [0:127] rk,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         rk_last
);

    if (NR != AES_NR) begin : g_nr_check
        $error("aes_key_expand_iter: only NR=10 is supported");
    end

    kx_state_t  state_q, state_d;
    aes_block_t rk_q, rk_d;
    logic [3:0] round_q, round_d;
    logic       mode_q, mode_d;

    aes_word_t  w0, w1, w2, w3;
    aes_word_t  w1p, w2p, w3p;
    aes_word_t  sw_in, sw_out, t;
    aes_word_t  f0, f1, f2, f3, r0;
    aes_block_t next_key;
    logic [3:0] rcon_idx;

    aes_sub_word u_sub_word (
        .din  (sw_in),
        .dout (sw_out)
    );

    // Next-key datapath straight off the rk register; the single SubWord is
    // shared by muxing its input (w3 forward, w3^w2 reverse).
    always_comb begin
        w0       = rk_q[0:31];
        w1       = rk_q[32:63];
        w2       = rk_q[64:95];
        w3       = rk_q[96:127];
        w3p      = w3 ^ w2;
        w2p      = w2 ^ w1;
        w1p      = w1 ^ w0;
        sw_in    = rot_word(mode_q ? w3p : w3);
        rcon_idx = mode_q ? round_q : round_q + 4'd1;
        t        = sw_out ^ rcon_word(rcon_idx);
        f0       = w0 ^ t;
        f1       = w1 ^ f0;
        f2       = w2 ^ f1;
        f3       = w3 ^ f2;
        r0       = w0 ^ t;
        next_key = mode_q ? {r0, w1p, w2p, w3p} : {f0, f1, f2, f3};
    end

    // Handshake FSM: capture in IDLE, walk the rounds in EMIT
    always_comb begin
        state_d   = state_q;
        rk_d      = rk_q;
        round_d   = round_q;
        mode_d    = mode_q;
        key_ready = 1'b0;
        rk_valid  = 1'b0;
        rk_last   = 1'b0;
        case (state_q)
            KX_IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    rk_d    = key_in;
                    mode_d  = decrypt;
                    round_d = decrypt ? 4'(NR) : 4'd0;
                    state_d = KX_EMIT;
                end
            end
            KX_EMIT: begin
                rk_valid = 1'b1;
                rk_last  = (round_q == 4'(NR) && !mode_q) || (round_q == 4'd0 && mode_q);
                if (rk_ready) begin
                    if (rk_last) begin
                        state_d = KX_IDLE;
                    end else begin
                        rk_d    = next_key;
                        round_d = mode_q ? round_q - 4'd1 : round_q + 4'd1;
                    end
                end
            end
            default: state_d = KX_IDLE;
        endcase
    end

    // State and key registers; reset abandons any sequence in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= KX_IDLE;
            rk_q    <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
            mode_q  <= mode_d;
        end
    end

    assign rk       = rk_q;
    assign rk_round = round_q;

endmodule

// File: tb/tb_aes_key_expand_iter.sv
// Scoreboard bench for aes_key_expand_iter against a word-array key-expansion model.
module tb_aes_key_expand_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic [0:127] key_in;
    logic         decrypt;
    logic         key_valid;
    logic         key_ready;
    logic [0:127] rk;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         rk_last;

    aes_key_expand_iter #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .decrypt   (decrypt),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk        (rk),
        .rk_round  (rk_round),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_last   (rk_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   rnd;
        logic         last;
    } exp_t;

    exp_t         sbq[$];
    int           errors = 0;
    int           checks = 0;
    logic [7:0]   sbox [256];
    logic [127:0] mrk [11];

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (a != 0 && gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
            b = inv;
            sbox[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                        ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Classic 44-word expansion; mrk[r] = words 4r..4r+3
    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t         e;
        logic         stall_prev;
        logic [127:0] rk_hold;
        logic [3:0]   rnd_hold;
        logic         last_hold;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid", 128'(rk_valid), 128'(1));
                    check("stall_rk", rk, rk_hold);
                    check("stall_round", 128'(rk_round), 128'(rnd_hold));
                    check("stall_last", 128'(rk_last), 128'(last_hold));
                end
                if (rk_valid && rk_ready) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rk: got round %0d key %h want no output", rk_round, rk);
                    end else begin
                        e = sbq.pop_front();
                        check($sformatf("rk_r%0d", e.rnd), rk, e.key);
                        check("rk_round", 128'(rk_round), 128'(e.rnd));
                        check($sformatf("rk_last_r%0d", e.rnd), 128'(rk_last), 128'(e.last));
                    end
                end
                stall_prev = rk_valid && !rk_ready;
                rk_hold    = rk;
                rnd_hold   = rk_round;
                last_hold  = rk_last;
            end
        end
    end

    // ---------------- stimulus ----------------
    // rmode: 0 ready high, 1 random ready, 2 random + 5-cycle stall at round 3,
    //        3 random ready with a competing key_valid during EMIT
    task automatic run(input logic [127:0] ck, input logic dec, input int rmode);
        exp_t         e;
        logic [127:0] send;
        int           w, cyc, stall;
        logic         fin, done;
        expand(ck);
        send = dec ? mrk[10] : ck;
        for (int j = 0; j < 11; j++) begin
            e.rnd  = dec ? 4'(10 - j) : 4'(j);
            e.key  = mrk[e.rnd];
            e.last = (j == 10);
            sbq.push_back(e);
        end
        w = 0;
        while (!key_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("idle_wait", 128'(key_ready), 128'(1));
        key_in    = send;
        decrypt   = dec;
        key_valid = 1'b1;
        rk_ready  = (rmode == 0);
        @(posedge clk); #1;
        check("latency_valid", 128'(rk_valid), 128'(1));
        key_valid = (rmode == 3);
        key_in    = ~send;
        decrypt   = ~dec;
        cyc = 0; stall = 0; done = 1'b0;
        while (!done && cyc < 300) begin
            case (rmode)
                0: rk_ready = 1'b1;
                2: begin
                    if (rk_round == 4'd3 && stall < 5) begin
                        rk_ready = 1'b0;
                        stall++;
                    end else begin
                        rk_ready = ($urandom % 3) != 0;
                    end
                end
                default: rk_ready = ($urandom % 3) != 0;
            endcase
            if (rmode == 3) check("busy_key_ready", 128'(key_ready), 128'(0));
            fin = rk_valid && rk_ready && rk_last;
            @(posedge clk); #1;
            cyc++;
            if (fin) done = 1'b1;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL seq_timeout: got %0d cycles without rk_last want completion", cyc);
        end
        if (rmode == 0) check("consecutive_cycles", 128'(cyc), 128'(11));
        key_valid = 1'b0;
        rk_ready  = 1'b0;
        check("end_key_ready", 128'(key_ready), 128'(1));
        check("end_rk_valid", 128'(rk_valid), 128'(0));
    endtask

    initial begin : stim
        int w;
        exp_t e;
        logic [127:0] fips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rst = 1'b1; key_in = '0; decrypt = 1'b0; key_valid = 1'b0; rk_ready = 1'b0;
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        check("rst_key_ready", 128'(key_ready), 128'(1));
        check("rst_rk_valid", 128'(rk_valid), 128'(0));
        check("rst_rk_last", 128'(rk_last), 128'(0));
        check("rst_rk", rk, 128'h0);
        check("rst_rk_round", 128'(rk_round), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Known-answer: model against published FIPS-197 values
        expand(fips);
        check("model_r1", mrk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("model_r9", mrk[9], 128'hac7766f319fadc2128d12941575c006e);
        check("model_r10", mrk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run(fips, 1'b0, 0);   // forward, ready high
        run(fips, 1'b1, 0);   // reverse from round-10 key
        run(fips, 1'b0, 2);   // backpressure with stall at round 3
        run(fips, 1'b1, 2);
        run(fips, 1'b0, 3);   // competing key during EMIT
        repeat (2) @(posedge clk);
        #1;
        check("busy_not_queued", 128'(rk_valid), 128'(0));

        // Reset at round 5
        expand(fips);
        key_in = fips; decrypt = 1'b0; key_valid = 1'b1; rk_ready = 1'b1;
        for (int j = 0; j < 11; j++) begin
            e.rnd = 4'(j); e.key = mrk[j]; e.last = (j == 10);
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        key_valid = 1'b0;
        w = 0;
        while (rk_round != 4'd5 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("reach_round5", 128'(rk_round), 128'(5));
        rk_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sbq.delete();
        check("mid_rst_rk_valid", 128'(rk_valid), 128'(0));
        check("mid_rst_rk", rk, 128'h0);
        check("mid_rst_rk_round", 128'(rk_round), 128'(0));
        check("mid_rst_key_ready", 128'(key_ready), 128'(1));
        check("mid_rst_rk_last", 128'(rk_last), 128'(0));
        run(fips, 1'b0, 0);

        // Random round trips
        for (int i = 0; i < 100; i++) begin
            logic [127:0] k;
            k = {$urandom, $urandom, $urandom, $urandom};
            run(k, 1'b0, (i % 2 == 0) ? 0 : 1);
            run(k, 1'b1, (i % 3 == 0) ? 1 : 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 128'(sbq.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
